dlfloat_operand_loader: RTL

Upstream feeder for the DLFloat16 MAC. It takes a byte-serial operand stream from the pad interface over a valid/ready handshake and assembles operand pairs (a, b). Subnormal encodings are flushed to zero. Assembled pairs are buffered in a small FIFO and presented to the MAC stage on a valid/ready interface, each tagged with a frame-start flag that tells the MAC to restart accumulation.

---
 rtl/dlfloat_pkg.sv | 32 +++
 rtl/dlfloat_pair_fifo.sv | 59 +++++
 rtl/dlfloat_operand_loader.sv | 129 ++++++++++++
 3 files changed

// File: rtl/dlfloat_pkg.sv
// Shared DLFloat16 definitions: field widths, special codes, the operand-pair
// record handed to the MAC, and the subnormal test.
package dlfloat_pkg;

  localparam int DLF_W    = 16;
  localparam int EXP_W    = 6;
  localparam int MANT_W   = 9;
  localparam int EXP_BIAS = 31;

  localparam logic [DLF_W-1:0] DLF_ZERO    = 16'h0000;
  localparam logic [DLF_W-1:0] DLF_SPECIAL = 16'hFFFF;

  typedef struct packed {
    logic             first;
    logic [DLF_W-1:0] a;
    logic [DLF_W-1:0] b;
  } dlf_pair_t;

  typedef enum logic [1:0] {
    A_HI = 2'd0,
    A_LO = 2'd1,
    B_HI = 2'd2,
    B_LO = 2'd3
  } asm_state_t;

  // Zero exponent with a non-zero mantissa. Zero itself and the all-ones
  // special code never qualify.
  function automatic logic is_subnormal(input logic [DLF_W-1:0] x);
    return (x[DLF_W-2 -: EXP_W] == '0) && (x[MANT_W-1:0] != '0);
  endfunction

endpackage

// File: rtl/dlfloat_pair_fifo.sv
// Small synchronous FIFO of operand pairs. Pointers carry one extra wrap bit
// so full and empty are told apart by the pointer difference alone.
module dlfloat_pair_fifo
  import dlfloat_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clr,
  input  logic             i_push,
  input  dlf_pair_t        i_wdata,
  input  logic             i_pop,
  output dlf_pair_t        o_rdata,
  output logic [LVL_W-1:0] o_level,
  output logic             o_full,
  output logic             o_empty
);

  localparam int ADDR_W = $clog2(DEPTH);

  dlf_pair_t        r_mem [DEPTH];
  logic [LVL_W-1:0] r_wr_ptr;
  logic [LVL_W-1:0] r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_full  = (o_level == LVL_W'(DEPTH));
  assign o_empty = (o_level == '0);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_rdata = r_mem[r_rd_ptr[ADDR_W-1:0]];

  // Pointer update; clear wins over any push or pop in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + LVL_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + LVL_W'(1);
    end
  end

  // Storage write; entries are zeroed on reset so the head reads 0 when empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push && !i_clr) begin
      r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_wdata;
    end
  end

endmodule

// File: rtl/dlfloat_operand_loader.sv
// Byte-serial operand loader for the DLFloat16 MAC. Assembles a/b pairs from
// a byte stream, flushes subnormals to zero and queues pairs for the MAC.
//
// state | meaning
// A_HI  | waiting for a[15:8]; frame_start is sampled with it
// A_LO  | waiting for a[7:0]
// B_HI  | waiting for b[15:8]
// B_LO  | waiting for b[7:0]; the pair is pushed when it arrives
module dlfloat_operand_loader
  import dlfloat_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       i_byte_in,
  input  logic             i_byte_valid,
  output logic             o_byte_ready,
  input  logic             i_frame_start,
  input  logic             i_sync_clr,
  output logic [15:0]      o_op_a,
  output logic [15:0]      o_op_b,
  output logic             o_op_first,
  output logic             o_op_valid,
  input  logic             i_op_ready,
  output logic [LVL_W-1:0] o_fifo_level,
  output logic             o_flush_seen
);

  asm_state_t       r_state;
  logic             r_first;
  logic [7:0]       r_a_hi;
  logic [7:0]       r_a_lo;
  logic [7:0]       r_b_hi;
  logic             r_flush_seen;

  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [15:0]      w_a_raw;
  logic [15:0]      w_b_raw;
  logic             w_flush;
  dlf_pair_t        w_wdata;
  dlf_pair_t        w_rdata;
  logic [LVL_W-1:0] w_level;

  // Sign and mantissa are deliberately not kept on a flush.
  function automatic logic [DLF_W-1:0] sanitize(input logic [DLF_W-1:0] x);
    return is_subnormal(x) ? DLF_ZERO : x;
  endfunction

  // Ready depends only on registered state, never on the MAC's op_ready.
  assign o_byte_ready = !((r_state == B_LO) && w_full);
  assign w_accept     = i_byte_valid && o_byte_ready;
  assign w_push       = w_accept && (r_state == B_LO) && !i_sync_clr;
  assign w_pop        = o_op_valid && i_op_ready;

  assign w_a_raw = {r_a_hi, r_a_lo};
  assign w_b_raw = {r_b_hi, i_byte_in};
  assign w_flush = is_subnormal(w_a_raw) || is_subnormal(w_b_raw);

  assign w_wdata.first = r_first;
  assign w_wdata.a     = sanitize(w_a_raw);
  assign w_wdata.b     = sanitize(w_b_raw);

  // Byte assembly FSM: one step per accepted byte, abort returns to A_HI.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= A_HI;
      r_first <= 1'b0;
      r_a_hi  <= '0;
      r_a_lo  <= '0;
      r_b_hi  <= '0;
    end else if (i_sync_clr) begin
      r_state <= A_HI;
    end else if (w_accept) begin
      case (r_state)
        A_HI: begin
          r_a_hi  <= i_byte_in;
          r_first <= i_frame_start;
          r_state <= A_LO;
        end
        A_LO: begin
          r_a_lo  <= i_byte_in;
          r_state <= B_HI;
        end
        B_HI: begin
          r_b_hi  <= i_byte_in;
          r_state <= B_LO;
        end
        default: r_state <= A_HI;
      endcase
    end
  end

  // Sticky flush indicator, set on the edge that pushes a flushed pair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_flush_seen <= 1'b0;
    else if (i_sync_clr)          r_flush_seen <= 1'b0;
    else if (w_push && w_flush)   r_flush_seen <= 1'b1;
  end

  dlfloat_pair_fifo #(
    .DEPTH (FIFO_DEPTH),
    .LVL_W (LVL_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_clr   (i_sync_clr),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign o_op_valid   = !w_empty;
  assign o_op_a       = w_rdata.a;
  assign o_op_b       = w_rdata.b;
  assign o_op_first   = w_rdata.first;
  assign o_fifo_level = w_level;
  assign o_flush_seen = r_flush_seen;

endmodule
